// File: rtl/pipeline_debug_front.sv
// Board front-end: debounced step/burst/run control of a flop-generated CPU clock, a cycle
// counter and a paged hex seven-segment scanner. DEBUG_FRONT_CYCLE_DISPLAY_EN adds show_cycle.
module pipeline_debug_front #(
  parameter int DATA_W          = 32,
  parameter int NUM_DIGITS      = 4,
  parameter int PAGE_W          = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HALF_PERIOD     = 50000,
  parameter int BURST_W         = 8,
  parameter int CNT_W           = 16,
  parameter int SCAN_DIV        = 100000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  step_btn,
  input  logic                  burst_btn,
  input  logic                  run_sw,
  input  logic [BURST_W-1:0]    burst_len,
  input  logic [PAGE_W-1:0]     page_sel,
  input  logic [DATA_W-1:0]     reg_data,
`ifdef DEBUG_FRONT_CYCLE_DISPLAY_EN
  input  logic                  show_cycle,
`endif
  output logic                  cpu_cycle,
  output logic                  busy,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic [6:0]            cathodes
);

  localparam int DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HP_W      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int SC_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NUM_PAGES = DATA_W / (4 * NUM_DIGITS);
  localparam int NIBBLES   = DATA_W / 4;

  // Input conditioning; bit 0 = step, 1 = burst, 2 = run.
  logic [2:0]      raw, sync1, sync2, deb;
  logic [1:0]      deb_d;
  logic [DB_W-1:0] db_cnt [3];
  logic            step_evt, burst_evt, run_on;

  assign raw = {run_sw, burst_btn, step_btn};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb[1:0];
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign step_evt  = deb[0] & ~deb_d[0];
  assign burst_evt = deb[1] & ~deb_d[1];
  assign run_on    = deb[2];

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t             state, state_nx;
  logic [HP_W-1:0]    phase_cnt;
  logic [BURST_W-1:0] remaining, remaining_nx;
  logic               phase_end;

  assign phase_end = (phase_cnt == HP_W'(HALF_PERIOD - 1));

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    case (state)
      IDLE: begin
        if (run_on) begin
          state_nx = HIGH;
        end else if (step_evt) begin
          state_nx     = HIGH;
          remaining_nx = BURST_W'(1);
        end else if (burst_evt && (burst_len != '0)) begin
          state_nx     = HIGH;
          remaining_nx = burst_len;
        end
      end
      HIGH: if (phase_end) state_nx = LOW;
      LOW: begin
        if (phase_end) begin
          // Run overrides any pending burst; once run drops, leftovers are discarded.
          if (run_on) begin
            state_nx     = HIGH;
            remaining_nx = '0;
          end else if (remaining > BURST_W'(1)) begin
            state_nx     = HIGH;
            remaining_nx = remaining - 1'b1;
          end else begin
            state_nx     = IDLE;
            remaining_nx = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      remaining   <= '0;
      cpu_cycle   <= 1'b0;
      cycle_count <= '0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      phase_cnt <= (state_nx != state || state == IDLE) ? '0 : phase_cnt + 1'b1;
      cpu_cycle <= (state_nx == HIGH);
      if (state_nx == HIGH && state != HIGH) cycle_count <= cycle_count + 1'b1;
    end
  end

  assign busy = (state != IDLE);

  logic [SC_W-1:0]   scan_cnt;
  logic [DIG_W-1:0]  digit_idx;
  logic [DATA_W-1:0] disp_src;
  logic [3:0]        nibble;
  logic              page_ok;
  int                nib_idx;

`ifdef DEBUG_FRONT_CYCLE_DISPLAY_EN
  assign disp_src = show_cycle ? DATA_W'(cycle_count) : reg_data;
`else
  assign disp_src = reg_data;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    page_ok = (int'(page_sel) < NUM_PAGES);
    nib_idx = int'(page_sel) * NUM_DIGITS + int'(digit_idx);
    nibble  = 4'h0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (n == nib_idx) nibble = disp_src[n*4 +: 4];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      anodes    <= '1;
      cathodes  <= '1;
    end else begin
      if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_idx <= (digit_idx == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      anodes   <= ~(NUM_DIGITS'(1) << digit_idx);
      cathodes <= page_ok ? seg7(nibble) : 7'h7F;
    end
  end

endmodule

// File: tb/tb_pipeline_debug_front.sv
// Directed bench for pipeline_debug_front: step/burst table, run wrap, display scan, async reset.
module tb_pipeline_debug_front;
  localparam int DATA_W = 32;
  localparam int NUM_DIGITS = 4;
  localparam int PAGE_W = 1;
  localparam int BURST_W = 8;
  localparam int CNT_W = 4;
  localparam int HP = 3;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  step_btn = 1'b0;
  logic                  burst_btn = 1'b0;
  logic                  run_sw = 1'b0;
  logic [BURST_W-1:0]    burst_len = '0;
  logic [PAGE_W-1:0]     page_sel = '0;
  logic [DATA_W-1:0]     reg_data = '0;
`ifdef DEBUG_FRONT_CYCLE_DISPLAY_EN
  logic                  show_cycle = 1'b0;
`endif
  logic                  cpu_cycle;
  logic                  busy;
  logic [CNT_W-1:0]      cycle_count;
  logic [NUM_DIGITS-1:0] anodes;
  logic [6:0]            cathodes;

  pipeline_debug_front #(
    .DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS), .PAGE_W(PAGE_W), .DEBOUNCE_CYCLES(4),
    .HALF_PERIOD(HP), .BURST_W(BURST_W), .CNT_W(CNT_W), .SCAN_DIV(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .step_btn(step_btn), .burst_btn(burst_btn),
    .run_sw(run_sw), .burst_len(burst_len), .page_sel(page_sel), .reg_data(reg_data),
`ifdef DEBUG_FRONT_CYCLE_DISPLAY_EN
    .show_cycle(show_cycle),
`endif
    .cpu_cycle(cpu_cycle), .busy(busy), .cycle_count(cycle_count),
    .anodes(anodes), .cathodes(cathodes)
  );

  // clock / reset
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase-length monitor: every HIGH and LOW phase must last HP clocks.
  int   rise_cnt = 0;
  int   hi_len = 0, lo_len = 0, busy_len = 0, last_busy_len = 0;
  logic prev_cpu = 1'b0, prev_busy = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      hi_len = 0; lo_len = 0; busy_len = 0;
      prev_cpu = 1'b0; prev_busy = 1'b0;
    end else begin
      if (cpu_cycle && !prev_cpu) begin
        rise_cnt++;
        if (prev_busy) check("low_phase", lo_len, HP);
        hi_len = 1; lo_len = 0;
      end else if (cpu_cycle) begin
        hi_len++;
      end else if (prev_cpu) begin
        check("high_phase", hi_len, HP);
        lo_len = 1;
      end else if (busy) begin
        lo_len++;
      end
      if (busy) busy_len++;
      if (prev_busy && !busy) begin
        check("final_low", lo_len, HP);
        last_busy_len = busy_len;
        busy_len = 0;
      end
      prev_cpu = cpu_cycle;
      prev_busy = busy;
    end
  end

  // driver tasks
  task automatic sample();
    @(negedge clock); #1;
  endtask

  task automatic press(input int kind, input logic [BURST_W-1:0] blen, input int hold);
    burst_len = blen;
    if (kind == 0) step_btn = 1'b1; else burst_btn = 1'b1;
    repeat (hold) @(posedge clock);
    #1;
    step_btn = 1'b0;
    burst_btn = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (10) @(posedge clock);
    sample();
    while (busy && t < 400) begin sample(); t++; end
    check("idle_timeout", 32'(busy), 0);
    repeat (3) sample();
  endtask

  task automatic wait_anodes(input logic [NUM_DIGITS-1:0] val);
    int t = 0;
    sample();
    while (anodes !== val && t < 40) begin sample(); t++; end
    check("anode_sync", 32'(anodes), 32'(val));
  endtask

  typedef struct {
    int               kind;
    logic [BURST_W-1:0] blen;
    int               hold;
    int               pulses;
    logic [CNT_W-1:0] count;
  } seq_vec_t;

  typedef struct {
    int                    page;
    int                    digit;
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            cat;
  } disp_vec_t;

  seq_vec_t  seq_tbl[7];
  disp_vec_t disp_tbl[8];

  initial begin
    int base;
    int t;
    int busy_seen;
    logic [10:0] exp;

    seq_tbl[0] = '{0, 8'd0, 2,  0, 4'd0};   // glitch rejected
    seq_tbl[1] = '{0, 8'd0, 10, 1, 4'd1};   // single step
    seq_tbl[2] = '{1, 8'd5, 10, 5, 4'd6};   // burst of 5
    seq_tbl[3] = '{1, 8'd0, 10, 0, 4'd6};   // zero-length burst ignored
    seq_tbl[4] = '{1, 8'd3, 10, 3, 4'd9};
    seq_tbl[5] = '{0, 8'd0, 10, 1, 4'd10};
    seq_tbl[6] = '{1, 8'd8, 10, 8, 4'd2};   // count wraps 15 -> 0

    disp_tbl[0] = '{0, 0, 4'b1110, 7'b0100001};
    disp_tbl[1] = '{0, 1, 4'b1101, 7'b1000110};
    disp_tbl[2] = '{0, 2, 4'b1011, 7'b0000011};
    disp_tbl[3] = '{0, 3, 4'b0111, 7'b0001000};
    disp_tbl[4] = '{1, 0, 4'b1110, 7'b0011001};
    disp_tbl[5] = '{1, 1, 4'b1101, 7'b0110000};
    disp_tbl[6] = '{1, 2, 4'b1011, 7'b0100100};
    disp_tbl[7] = '{1, 3, 4'b0111, 7'b1111001};

    repeat (3) @(posedge clock);
    #1;
    check("rst_cpu_cycle", 32'(cpu_cycle), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(cycle_count), 0);
    check("rst_anodes", 32'(anodes), 32'hF);
    check("rst_cathodes", 32'(cathodes), 32'h7F);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) sample();

    for (int i = 0; i < 7; i++) begin
      base = rise_cnt;
      press(seq_tbl[i].kind, seq_tbl[i].blen, seq_tbl[i].hold);
      wait_idle();
      check($sformatf("seq%0d_pulses", i), rise_cnt - base, seq_tbl[i].pulses);
      check($sformatf("seq%0d_count", i), 32'(cycle_count), 32'(seq_tbl[i].count));
      if (seq_tbl[i].pulses > 0)
        check($sformatf("seq%0d_busy_len", i), last_busy_len, 2 * HP * seq_tbl[i].pulses);
    end

    // Step pressed during a burst is dropped.
    base = rise_cnt;
    press(1, 8'd5, 10);
    repeat (8) @(posedge clock);
    check("midburst_busy", 32'(busy), 1);
    press(0, 8'd5, 10);
    wait_idle();
    check("midburst_pulses", rise_cnt - base, 5);
    check("midburst_count", 32'(cycle_count), 7);

    // Asynchronous reset while cpu_cycle is high.
    step_btn = 1'b1;
    t = 0;
    sample();
    while (!cpu_cycle && t < 40) begin sample(); t++; end
    check("pre_reset_high", 32'(cpu_cycle), 1);
    step_btn = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_cpu_cycle", 32'(cpu_cycle), 0);
    check("async_busy", 32'(busy), 0);
    check("async_count", 32'(cycle_count), 0);
    check("async_anodes", 32'(anodes), 32'hF);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (busy || cpu_cycle) busy_seen++;
    end
    check("post_reset_idle", busy_seen, 0);

    // Free run for 20 pulses, then drop run during the next HIGH phase.
    base = rise_cnt;
    run_sw = 1'b1;
    t = 0;
    while ((rise_cnt - base) < 20 && t < 1000) begin sample(); t++; end
    check("run_rises", rise_cnt - base, 20);
    check("run_wrap_count", 32'(cycle_count), 4);
    @(posedge clock);
    #1;
    run_sw = 1'b0;
    wait_idle();
    check("run_stop_rises", rise_cnt - base, 21);
    check("run_stop_count", 32'(cycle_count), 5);
    check("run_stop_cpu", 32'(cpu_cycle), 0);

    // Display scan, pages 0 and 1 (scoreboard via expected queue).
    reg_data = 32'h1234ABCD;
    for (int p = 0; p < 2; p++) begin
      page_sel = PAGE_W'(p);
      wait_anodes(4'b0111);
      wait_anodes(4'b1110);
      for (int d = 0; d < 4; d++) begin
        exp_q.push_back({disp_tbl[p*4+d].an, disp_tbl[p*4+d].cat});
        exp = exp_q.pop_front();
        check($sformatf("disp_p%0d_d%0d", p, d), 32'({anodes, cathodes}), 32'(exp));
        sample();
        sample();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
